// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NREQ valid/ready requesters.
// Optional macro ALU_ARB_DIVZERO_EN short-circuits divide-by-zero with an error response.
module alu_arbiter #(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  input  logic [NREQ*(M-1)-1:0]    req_op,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [N-1:0]             resp_data,
  output logic                     resp_err,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [M-2:0]             alu_instruction,
  input  logic [N-1:0]             alu_out
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   tag_reg;
  logic             err_reg;
  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic             divz_hit;

  logic [N-1:0]     a_arr  [NREQ];
  logic [N-1:0]     b_arr  [NREQ];
  logic [M-2:0]     op_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[gi*N +: N];
    assign b_arr[gi]  = req_b[gi*N +: N];
    assign op_arr[gi] = req_op[gi*(M-1) +: (M-1)];
  end

  // Walk from farthest to nearest so the closest requester after rr_ptr wins.
  always_comb begin
    int idx;
    grant     = '0;
    any_valid = |req_valid;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (req_valid[idx]) grant = idx[IDW-1:0];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && any_valid) req_ready[grant] = 1'b1;
  end

`ifdef ALU_ARB_DIVZERO_EN
  assign divz_hit = any_valid && (op_arr[grant] == (M-1)'(3)) && (b_arr[grant] == '0);
`else
  assign divz_hit = 1'b0;
`endif

  assign resp_err = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= IDW'(NREQ-1);
      tag_reg         <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_instruction <= '0;
      resp_data       <= '0;
      resp_id         <= '0;
      resp_valid      <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            rr_ptr_reg <= grant;
            if (divz_hit) begin
              // Answered locally; the ALU operand registers keep their old values.
              resp_data  <= '1;
              resp_id    <= grant;
              resp_valid <= 1'b1;
              err_reg    <= 1'b1;
              state_reg  <= RESP;
            end else begin
              alu_a           <= a_arr[grant];
              alu_b           <= b_arr[grant];
              alu_instruction <= op_arr[grant];
              tag_reg         <= grant;
              state_reg       <= EXEC;
            end
          end
        end
        EXEC: state_reg <= CAPT;
        CAPT: begin
          resp_data  <= alu_out;
          resp_id    <= tag_reg;
          resp_valid <= 1'b1;
          err_reg    <= 1'b0;
          state_reg  <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            err_reg    <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic        resp_valid, resp_ready, resp_err;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data, alu_a, alu_b;
  logic [2:0]  alu_instruction;
  logic [7:0]  alu_out = 8'h00;

  alu_arbiter #(.N(8), .M(4), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instruction(alu_instruction), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[7:0];
      3'd3: return (b == 8'h00) ? 8'hFF : a / b;
      3'd4: return {a[6:0], 1'b0};
      3'd5: return {1'b0, a[7:1]};
      3'd6: return {a[6:0], a[7]};
      default: return {a[0], a[7:1]};
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_instruction);

  typedef struct packed { logic [1:0] id; logic [7:0] data; logic err; } exp_t;
  exp_t sb[$];
  int grant_log[$];
  int grant_cyc[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, ngrants = 0, nresp = 0, last_grant_cyc = 0, lat_last = -1;
  logic       prev_valid = 1'b0, prev_stall = 1'b0;
  logic [7:0] held_data, last_data;
  logic [1:0] held_id, last_id;
  logic       held_err, last_err;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t expect_for(int g);
    exp_t e;
    logic [7:0] a, b;
    logic [2:0] op;
    a = req_a[g*8 +: 8]; b = req_b[g*8 +: 8]; op = req_op[g*3 +: 3];
    e.id = 2'(g);
    e.data = alu_f(a, b, op);
    e.err = 1'b0;
`ifdef ALU_ARB_DIVZERO_EN
    if (op == 3'd3 && b == 8'h00) begin
      e.data = 8'hFF;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    if (rst) return;
    check("ready_onehot", 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == 4'b0)), 32'd1);
    for (int g = 0; g < 4; g++)
      if (req_ready[g]) begin
        sb.push_back(expect_for(g));
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
        last_grant_cyc = cyc;
        ngrants++;
        $display("grant  cyc=%0d id=%0d", cyc, g);
      end
    if (resp_valid && !prev_valid) lat_last = cyc - last_grant_cyc;
    if (resp_valid) check("no_ready_busy", 32'(req_ready), 32'd0);
    if (resp_valid && prev_stall) begin
      check("hold_data", 32'(resp_data), 32'(held_data));
      check("hold_id", 32'(resp_id), 32'(held_id));
      check("hold_err", 32'(resp_err), 32'(held_err));
    end
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_data", 32'(resp_data), 32'(e.data));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
      last_data = resp_data; last_id = resp_id; last_err = resp_err;
      nresp++;
      $display("resp   cyc=%0d id=%0d data=%02h err=%0b lat=%0d", cyc, resp_id, resp_data, resp_err, lat_last);
    end
    prev_valid = resp_valid;
    prev_stall = resp_valid && !resp_ready;
    held_data = resp_data; held_id = resp_id; held_err = resp_err;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*3 +: 3] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grants(int n);
    int start = ngrants;
    int k = 0;
    while (ngrants < start + n && k < 60) begin tick(); k++; end
    check("grant_wait", 32'(ngrants - start), 32'(n));
  endtask

  task automatic wait_resps(int n);
    int start = nresp;
    int k = 0;
    while (nresp < start + n && k < 60) begin tick(); k++; end
    check("resp_wait", 32'(nresp - start), 32'(n));
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || resp_valid) && k < 100) begin tick(); k++; end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    prev_valid = 1'b0; prev_stall = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int r0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_instr", 32'(alu_instruction), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single request: 5 + 3
    set_req(0, 8'h05, 8'h03, 3'd0);
    wait_grants(1);
    req_valid = '0;
    check("t1_grant", 32'(grant_log[$]), 32'd0);
    wait_resps(1);
    check("t1_data", 32'(last_data), 32'h08);
    check("t1_latency", 32'(lat_last), 32'd3);

    // Round robin from a fresh reset: 0,1,2,3,0 spaced 4 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'h10, 8'h01, 3'd1);
    base = grant_log.size();
    wait_grants(5);
    req_valid = '0;
    for (int j = 0; j < 5; j++) check("t2_order", 32'(grant_log[base+j]), 32'(j % 4));
    for (int j = 1; j < 5; j++) check("t2_spacing", 32'(grant_cyc[base+j] - grant_cyc[base+j-1]), 32'd4);
    drain();
    check("t2_data", 32'(last_data), 32'h0F);

    // Backpressure: truncated multiply held while resp_ready is low
    resp_ready = 1'b0;
    set_req(2, 8'h11, 8'h10, 3'd2);
    wait_grants(1);
    req_valid = '0;
    set_req(1, 8'h07, 8'h02, 3'd0);
    begin
      int k = 0;
      while (!resp_valid && k < 20) begin tick(); k++; end
    end
    check("t3_valid", 32'(resp_valid), 32'd1);
    repeat (5) tick();
    check("t3_data", 32'(resp_data), 32'h10);
    check("t3_id", 32'(resp_id), 32'd2);
    resp_ready = 1'b1;
    tick();
    check("t3_drop", 32'(resp_valid), 32'd0);
    wait_grants(1);
    req_valid = '0;
    check("t3_next_grant", 32'(grant_log[$]), 32'd1);
    drain();

    // Asynchronous reset during EXEC discards the transaction
    set_req(1, 8'h81, 8'h5A, 3'd6);
    wait_grants(1);
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    check("t4_resp_valid", 32'(resp_valid), 32'd0);
    check("t4_alu_a", 32'(alu_a), 32'd0);
    check("t4_alu_b", 32'(alu_b), 32'd0);
    check("t4_alu_instr", 32'(alu_instruction), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    prev_valid = 1'b0; prev_stall = 1'b0;
    r0 = nresp;
    repeat (6) tick();
    check("t4_no_resp", 32'(nresp), 32'(r0));
    set_req(1, 8'h81, 8'h5A, 3'd6);
    wait_grants(1);
    req_valid = '0;
    wait_resps(1);
    check("t4_rotl", 32'(last_data), 32'h03);

    // Divide by zero
    set_req(3, 8'h20, 8'h00, 3'd3);
    wait_grants(1);
    req_valid = '0;
    wait_resps(1);
`ifdef ALU_ARB_DIVZERO_EN
    check("t5_latency", 32'(lat_last), 32'd1);
    check("t5_err", 32'(last_err), 32'd1);
    check("t5_data", 32'(last_data), 32'hFF);
`else
    check("t5_latency", 32'(lat_last), 32'd3);
    check("t5_err", 32'(last_err), 32'd0);
`endif

    // Starvation: req0 held, req1 pulsed right after each req0 grant
    set_req(0, 8'h01, 8'h02, 3'd0);
    for (int n = 0; n < 3; n++) begin
      wait_grants(1);
      check("t6_req0", 32'(grant_log[$]), 32'd0);
      set_req(1, 8'h03, 8'h04, 3'd1);
      wait_grants(1);
      req_valid[1] = 1'b0;
      check("t6_req1", 32'(grant_log[$]), 32'd1);
    end
    req_valid = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
